// File: rtl/reg_view_ctrl.sv
// reg_view_ctrl: selects the register shown on the FPGA display and fetches its value
// through the register file's shared debug read port.
//
// The index moves on button ticks or on an auto-scan timer. A read is re-issued
// periodically so the displayed value follows the running program. A capture whose
// address no longer matches the selected index is discarded and re-read at once.
//
// Optional feature: define REG_VIEW_SKIP_ZERO_EN to skip index 0 (x0 is hardwired zero).
// The index then wraps 31 -> 1 and 1 -> 31, and resets to 1.
//
// Ports:
//   clk        in   system clock, posedge
//   rst        in   synchronous active-high reset
//   tick_r     in   one-cycle pulse, next register
//   tick_l     in   one-cycle pulse, previous register
//   auto_scan  in   level, advance index every SCAN_CYCLES
//   rd_req     out  debug read request
//   rd_addr    out  debug read address, stable while rd_req=1
//   rd_gnt     in   core grants the debug port this cycle
//   rd_data    in   read data, valid the cycle after rd_req && rd_gnt
//   data_reg   out  last captured register value
//   data_valid out  data_reg belongs to the current leds index
//   leds       out  selected register index
module reg_view_ctrl #(
    parameter int unsigned REFRESH_CYCLES = 50_000_000,
    parameter int unsigned SCAN_CYCLES    = 100_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_r,
    input  logic        tick_l,
    input  logic        auto_scan,
    output logic        rd_req,
    output logic [4:0]  rd_addr,
    input  logic        rd_gnt,
    input  logic [31:0] rd_data,
    output logic [31:0] data_reg,
    output logic        data_valid,
    output logic [4:0]  leds
);

    localparam int unsigned RefW  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int unsigned ScanW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

    localparam logic [RefW-1:0]  RefLast  = RefW'(REFRESH_CYCLES - 1);
    localparam logic [ScanW-1:0] ScanLast = ScanW'(SCAN_CYCLES - 1);

`ifdef REG_VIEW_SKIP_ZERO_EN
    localparam logic [4:0] RstIdx = 5'd1;
`else
    localparam logic [4:0] RstIdx = 5'd0;
`endif

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StCap
    } state_e;

    state_e            state_q;
    logic [RefW-1:0]   refresh_cnt_q;
    logic [ScanW-1:0]  scan_cnt_q;
    logic              pending_q;

    logic       scan_expire;
    logic       refresh_wrap;
    logic       step_fwd;
    logic       step_back;
    logic       idx_change;
    logic [4:0] idx_next;
    logic [4:0] idx_prev;

    always_comb begin
        scan_expire  = auto_scan && (scan_cnt_q == ScanLast);
        refresh_wrap = (refresh_cnt_q == RefLast);
        // A scan expiry behaves like tick_r; opposing requests cancel.
        step_fwd     = (tick_r | scan_expire) & ~tick_l;
        step_back    = tick_l & ~(tick_r | scan_expire);
        idx_change   = step_fwd | step_back;
`ifdef REG_VIEW_SKIP_ZERO_EN
        idx_next     = (leds == 5'd31) ? 5'd1 : leds + 5'd1;
        idx_prev     = (leds == 5'd1) ? 5'd31 : leds - 5'd1;
`else
        idx_next     = leds + 5'd1;
        idx_prev     = leds - 5'd1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            leds          <= RstIdx;
            rd_addr       <= RstIdx;
            rd_req        <= 1'b0;
            data_reg      <= 32'd0;
            data_valid    <= 1'b0;
            pending_q     <= 1'b0;
            refresh_cnt_q <= '0;
            scan_cnt_q    <= '0;
        end else begin
            refresh_cnt_q <= refresh_wrap ? '0 : refresh_cnt_q + 1'b1;

            if (!auto_scan || scan_expire) begin
                scan_cnt_q <= '0;
            end else begin
                scan_cnt_q <= scan_cnt_q + 1'b1;
            end

            if (step_fwd) begin
                leds <= idx_next;
            end else if (step_back) begin
                leds <= idx_prev;
            end

            case (state_q)
                StIdle: begin
                    if (pending_q) begin
                        rd_addr   <= leds;
                        rd_req    <= 1'b1;
                        pending_q <= 1'b0;
                        state_q   <= StReq;
                    end
                end
                StReq: begin
                    // rd_addr stays frozen; the core may stall us indefinitely.
                    if (rd_gnt) begin
                        rd_req  <= 1'b0;
                        state_q <= StCap;
                    end
                end
                StCap: begin
                    data_reg <= rd_data;
                    if (rd_addr == leds) begin
                        data_valid <= 1'b1;
                    end else begin
                        // Index moved while the read was in flight: discard and re-read.
                        pending_q <= 1'b1;
                    end
                    state_q <= StIdle;
                end
                default: begin
                    rd_req  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase

            // Later assignments win: an index change invalidates even a same-cycle capture,
            // and any new cause re-arms the read even if IDLE just consumed the flag.
            if (idx_change) begin
                data_valid <= 1'b0;
            end
            if (idx_change || refresh_wrap) begin
                pending_q <= 1'b1;
            end
        end
    end

endmodule
